// File: rtl/aes_sub_shift_seq_if.sv
// Handshake bundle for the sequential SubBytes/ShiftRows stage.
// The stage itself takes the slave view; whoever feeds it and drains it takes the master view.
interface aes_sub_shift_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_sub_shift_seq.sv
// AES SubBytes+ShiftRows (mode 0) or InvSubBytes+InvShiftRows (mode 1), LANES bytes per clock.
// A block takes 16/LANES substitution cycles; the shifted result is registered and held until drained.
module aes_sub_shift_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  aes_sub_shift_seq_if.slave bus
);
  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_sub_shift_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // S-boxes are built from the GF(2^8) inverse plus the affine map rather than a 256-entry table.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           mode_reg, mode_next;
  logic [127:0]   data_reg, data_next;
  logic [127:0]   out_data_reg, out_data_next;
  logic           in_ready_c;

  logic [7:0]     byte_arr [16];
  logic [3:0]     lane_idx [LANES];
  logic [7:0]     lane_out [LANES];
  logic [127:0]   sub_state;
  logic [127:0]   shift_state;

  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    assign byte_arr[gi] = data_reg[127-8*gi -: 8];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
    logic [7:0] lane_in;
    assign lane_idx[gi] = 4'(int'(cnt_reg) * LANES + gi);
    assign lane_in      = byte_arr[lane_idx[gi]];
    assign lane_out[gi] = mode_reg ? sbox_inv(lane_in) : sbox_fwd(lane_in);
  end

  // Byte k is rewritten only on the cycle whose counter selects its chunk.
  for (genvar gi = 0; gi < 16; gi++) begin : g_merge
    localparam int LN = gi % LANES;
    localparam int CH = gi / LANES;
    assign sub_state[127-8*gi -: 8] = (int'(cnt_reg) == CH) ? lane_out[LN] : byte_arr[gi];
  end

  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < 4; gc++) begin : g_col
      localparam int SF = 4 * ((gc + gr) % 4) + gr;
      localparam int SI = 4 * ((gc - gr + 4) % 4) + gr;
      assign shift_state[127-8*(4*gc+gr) -: 8] =
          mode_reg ? sub_state[127-8*SI -: 8] : sub_state[127-8*SF -: 8];
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    mode_next     = mode_reg;
    data_next     = data_reg;
    out_data_next = out_data_reg;
    in_ready_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          data_next  = bus.in_data;
          mode_next  = bus.in_mode;
          cnt_next   = '0;
          state_next = SUB;
        end
      end
      SUB: begin
        data_next = sub_state;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == CW'(N - 1)) begin
          out_data_next = shift_state;
          cnt_next      = '0;
          state_next    = DONE;
        end
      end
      DONE: begin
        // Draining and refilling share one edge, so in_ready follows out_ready here.
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            data_next  = bus.in_data;
            mode_next  = bus.in_mode;
            cnt_next   = '0;
            state_next = SUB;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      mode_reg     <= 1'b0;
      data_reg     <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      mode_reg     <= mode_next;
      data_reg     <= data_next;
      out_data_reg <= out_data_next;
    end
  end

  assign bus.in_ready  = in_ready_c & ~rst;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_data  = out_data_reg;
  assign bus.busy      = (state_reg == SUB) || (state_reg == DONE);
endmodule

// File: tb/tb_aes_sub_shift_seq.sv
// Directed bench for aes_sub_shift_seq: FIPS-197 vectors, backpressure, mode isolation,
// mid-operation reset, LANES latency sweep and a random forward/inverse round trip.
module tb_aes_sub_shift_seq;
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam int           NMAIN    = 4;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic rst_sw = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  always #5 clk = ~clk;

  aes_sub_shift_seq_if mif ();
  aes_sub_shift_seq #(.LANES(4)) dut (.clk(clk), .rst(rst), .bus(mif.slave));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         mode;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t tbl [8];

  // Offer one block, wait for the result; optionally scramble inputs while it is in flight.
  task automatic run_block(input logic m, input logic [127:0] d, input bit junk,
                           output logic [127:0] r, output int lat);
    int guard;
    mif.in_valid = 1'b1;
    mif.in_data  = d;
    mif.in_mode  = m;
    guard = 0;
    while (!mif.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("accept_ready", 128'(mif.in_ready), 128'(1));
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    lat = 0;
    while (!mif.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (junk && !mif.out_valid) begin
        mif.in_valid = 1'b1;
        mif.in_mode  = ~mif.in_mode;
        mif.in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    mif.in_valid = 1'b0;
    r = mif.out_data;
  endtask

  // Latency sweep: one instance per legal LANES, each on its own reset.
  for (genvar gi = 0; gi < 5; gi++) begin : g_sw
    localparam int LV = 1 << gi;
    localparam int NV = 16 / LV;
    bit done_f = 1'b0;
    aes_sub_shift_seq_if sif ();
    aes_sub_shift_seq #(.LANES(LV)) u_sw (.clk(clk), .rst(rst_sw), .bus(sif.slave));

    initial begin : sw_run
      int lat;
      sif.in_valid  = 1'b0;
      sif.in_data   = '0;
      sif.in_mode   = 1'b0;
      sif.out_ready = 1'b1;
      while (rst_sw) begin
        @(posedge clk); #1;
      end
      for (int v = 0; v < 2; v++) begin
        sif.in_valid = 1'b1;
        sif.in_mode  = v[0];
        sif.in_data  = v[0] ? FIPS_OUT : FIPS_IN;
        #1;
        chk($sformatf("lanes%0d_ready%0d", LV, v), 128'(sif.in_ready), 128'(1));
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        lat = 0;
        while (!sif.out_valid && lat < 40) begin
          @(posedge clk); #1;
          lat++;
        end
        chk($sformatf("lanes%0d_lat%0d", LV, v), 128'(lat), 128'(NV));
        chk($sformatf("lanes%0d_data%0d", LV, v), sif.out_data, v[0] ? FIPS_IN : FIPS_OUT);
        $display("sweep lanes=%0d mode=%0d lat=%0d out=%h", LV, v, lat, sif.out_data);
      end
      done_f = 1'b1;
    end
  end

  initial begin
    logic [127:0] r, r1, r2, d, held;
    int lat;

    tbl[0] = '{1'b0, FIPS_IN, FIPS_OUT};
    tbl[1] = '{1'b1, FIPS_OUT, FIPS_IN};
    tbl[2] = '{1'b0, {16{8'h00}}, {16{8'h63}}};
    tbl[3] = '{1'b1, {16{8'h63}}, {16{8'h00}}};
    tbl[4] = '{1'b0, {16{8'hff}}, {16{8'h16}}};
    tbl[5] = '{1'b1, {16{8'h16}}, {16{8'hff}}};
    tbl[6] = '{1'b0, 128'ha49c7ff2689f352b6b5bea43026a5049, 128'h49db873b453953897f02d2f177de961a};
    tbl[7] = '{1'b1, 128'h49db873b453953897f02d2f177de961a, 128'ha49c7ff2689f352b6b5bea43026a5049};

    mif.in_valid  = 1'b0;
    mif.in_data   = '0;
    mif.in_mode   = 1'b0;
    mif.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(mif.out_valid), 128'(0));
    chk("rst_busy", 128'(mif.busy), 128'(0));
    chk("rst_in_ready", 128'(mif.in_ready), 128'(0));
    chk("rst_out_data", mif.out_data, '0);
    rst    = 1'b0;
    rst_sw = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(mif.in_ready), 128'(1));

    for (int i = 0; i < 8; i++) begin
      run_block(tbl[i].mode, tbl[i].din, 1'b0, r, lat);
      chk($sformatf("vec%0d_data", i), r, tbl[i].dout);
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(NMAIN));
      $display("vec %0d mode=%0d in=%h out=%h lat=%0d", i, tbl[i].mode, tbl[i].din, r, lat);
    end

    // Backpressure: result held in DONE, then drain and accept on the same edge.
    @(posedge clk); #1;
    mif.out_ready = 1'b0;
    run_block(1'b0, FIPS_IN, 1'b0, held, lat);
    chk("bp_first", held, FIPS_OUT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_data%0d", i), mif.out_data, FIPS_OUT);
      chk($sformatf("bp_hold_ready%0d", i), 128'(mif.in_ready), 128'(0));
      chk($sformatf("bp_hold_valid%0d", i), 128'(mif.out_valid), 128'(1));
    end
    mif.in_valid  = 1'b1;
    mif.in_mode   = 1'b1;
    mif.in_data   = FIPS_OUT;
    mif.out_ready = 1'b1;
    #1;
    chk("bp_ready_follows", 128'(mif.in_ready), 128'(1));
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    chk("bp_drained", 128'(mif.out_valid), 128'(0));
    chk("bp_busy", 128'(mif.busy), 128'(1));
    lat = 0;
    while (!mif.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_next_lat", 128'(lat), 128'(NMAIN));
    chk("bp_next_data", mif.out_data, FIPS_IN);
    $display("backpressure held=%h next=%h lat=%0d", held, mif.out_data, lat);

    // Mode isolation: junk data and toggling mode while substituting.
    run_block(1'b0, FIPS_IN, 1'b1, r, lat);
    chk("iso_data", r, FIPS_OUT);
    chk("iso_lat", 128'(lat), 128'(NMAIN));
    $display("isolation out=%h lat=%0d", r, lat);

    // Reset in the middle of SUB drops the block and clears the output.
    mif.in_valid = 1'b1;
    mif.in_mode  = 1'b0;
    mif.in_data  = tbl[6].din;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_before", 128'(mif.busy), 128'(1));
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_in_ready_low", 128'(mif.in_ready), 128'(0));
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(mif.out_valid), 128'(0));
    chk("midrst_out_data", mif.out_data, '0);
    chk("midrst_busy", 128'(mif.busy), 128'(0));
    chk("midrst_in_ready", 128'(mif.in_ready), 128'(1));
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_output", 128'(mif.out_valid), 128'(0));
    $display("midop reset out_valid=%0d out_data=%h", mif.out_valid, mif.out_data);

    for (int i = 0; i < 1000; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block(1'b0, d, 1'b0, r1, lat);
      run_block(1'b1, r1, 1'b0, r2, lat);
      chk($sformatf("roundtrip%0d", i), r2, d);
      $display("rt %0d in=%h fwd=%h back=%h", i, d, r1, r2);
    end

    chk("sweep_done", 128'({g_sw[0].done_f, g_sw[1].done_f, g_sw[2].done_f,
                            g_sw[3].done_f, g_sw[4].done_f}), 128'(5'b11111));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
